seven_segment_arbiter: RTL and testbench



---
 rtl/seven_segment_arbiter.sv | 133 +++++++++++++
 tb/tb_seven_segment_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_arbiter.sv
// Round-robin arbiter that shares one two-digit seven-segment display between
// N_REQ requesters, holding each granted byte on the display for a fixed dwell.
module seven_segment_arbiter #(
  parameter int CLK_HZ  = 48_000_000,
  parameter int N_REQ   = 4,
  parameter int HOLD_MS = 500
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [N_REQ-1:0]                      i_req_valid,
  input  logic [8*N_REQ-1:0]                    i_req_data,
  output logic [N_REQ-1:0]                      o_req_ready,
  output logic [7:0]                            o_data,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] o_owner,
  output logic                                  o_active
);

  localparam int HOLD_CYCLES = (CLK_HZ / 1000) * HOLD_MS;
  localparam int OW          = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW          = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e            state_q,  state_d;
  logic [OW-1:0]     grant_q,  grant_d;
  logic [OW-1:0]     last_q,   last_d;
  logic [OW-1:0]     owner_q,  owner_d;
  logic [7:0]        data_q,   data_d;
  logic              active_q, active_d;
  logic [N_REQ-1:0]  ready_q,  ready_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  logic [OW-1:0]     pick_s;

  // Scan from last+N_REQ down to last+1 so the nearest valid index after last wins.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [OW-1:0]    last);
    logic [OW-1:0] pick;
    int            idx;
    pick = last;
    for (int off = N_REQ; off >= 1; off--) begin
      idx  = (int'(last) + off) % N_REQ;
      pick = valid[idx] ? OW'(idx) : pick;
    end
    return pick;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign pick_s = rr_pick(i_req_valid, last_q);

  // Next-state and registered-output logic for the IDLE/GRANT/HOLD sequence.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    owner_d  = owner_q;
    data_d   = data_q;
    active_d = active_q;
    ready_d  = {N_REQ{1'b0}};
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|i_req_valid) begin
          grant_d = pick_s;
          ready_d = onehot(pick_s);
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // A requester that dropped valid during GRANT forfeits its turn.
        if (i_req_valid[grant_q]) begin
          data_d   = i_req_data[int'(grant_q)*8 +: 8];
          owner_d  = grant_q;
          last_d   = grant_q;
          cnt_d    = CW'(HOLD_CYCLES - 1);
          active_d = 1'b1;
          state_d  = ST_HOLD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == {CW{1'b0}}) begin
          active_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d    = cnt_q - CW'(1);
        end
      end
      default: begin
        active_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= {OW{1'b0}};
      last_q   <= OW'(N_REQ - 1);
      owner_q  <= {OW{1'b0}};
      data_q   <= 8'h00;
      active_q <= 1'b0;
      ready_q  <= {N_REQ{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_data      = data_q;
  assign o_owner     = owner_q;
  assign o_active    = active_q;

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Scoreboard bench for seven_segment_arbiter: stimulus queues expected grants
// and captures, a negedge monitor compares what the display arbiter presents.
module tb_seven_segment_arbiter;

  localparam int N_REQ = 4;
  localparam int HOLD  = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [3:0]  i_req_valid;
  logic [31:0] i_req_data;
  logic [3:0]  o_req_ready;
  logic [7:0]  o_data;
  logic [1:0]  o_owner;
  logic        o_active;

  seven_segment_arbiter #(.CLK_HZ(1000), .N_REQ(N_REQ), .HOLD_MS(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_data      (o_data),
    .o_owner     (o_owner),
    .o_active    (o_active)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [3:0] ready; } grant_t;
  typedef struct { int cyc; logic [7:0] data; logic [1:0] owner; } cap_t;
  grant_t grant_q[$];
  cap_t   cap_q[$];

  int   n_pass = 0;
  int   n_total = 0;
  logic chk_en = 1'b0;
  logic [7:0] chk_data = 8'h00;
  logic [1:0] chk_owner = 2'd0;
  logic done = 1'b0;
  logic mon_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    else n_pass++;
  endtask

  // Monitor: all comparisons are made here, sampled on the falling edge.
  initial begin : monitor
    logic   prev_active;
    int     act_len;
    grant_t g;
    cap_t   c;
    prev_active = 1'b0;
    act_len = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        chk("reset_outputs", {17'd0, o_req_ready, o_data, o_owner, o_active}, 32'd0);
        prev_active = 1'b0;
        act_len = 0;
      end else begin
        if (o_req_ready != 4'b0000) begin
          if (grant_q.size() == 0) begin
            chk("unexpected_grant", {28'd0, o_req_ready}, 32'd0);
          end else begin
            g = grant_q.pop_front();
            chk("grant_cycle", cyc, g.cyc);
            chk("grant_ready", {28'd0, o_req_ready}, {28'd0, g.ready});
          end
        end
        if (o_active && !prev_active) begin
          act_len = 1;
          if (cap_q.size() == 0) begin
            chk("unexpected_capture", {24'd0, o_data}, 32'd0);
          end else begin
            c = cap_q.pop_front();
            chk("capture_cycle", cyc, c.cyc);
            chk("capture_data", {24'd0, o_data}, {24'd0, c.data});
            chk("capture_owner", {30'd0, o_owner}, {30'd0, c.owner});
          end
        end else if (o_active) begin
          act_len++;
        end else if (prev_active) begin
          chk("active_len", act_len, HOLD);
        end
        if (chk_en) begin
          chk("held_data", {24'd0, o_data}, {24'd0, chk_data});
          chk("held_owner", {30'd0, o_owner}, {30'd0, chk_owner});
          chk("held_inactive", {31'd0, o_active}, 32'd0);
        end
        prev_active = o_active;
      end
      if (done && !mon_done) begin
        chk("grants_left", grant_q.size(), 0);
        chk("captures_left", cap_q.size(), 0);
        mon_done = 1'b1;
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic exp_grant(input int c, input logic [3:0] r);
    grant_t g;
    g.cyc = c;
    g.ready = r;
    grant_q.push_back(g);
  endtask

  task automatic exp_cap(input int c, input logic [7:0] d, input logic [1:0] o);
    cap_t x;
    x.cyc = c;
    x.data = d;
    x.owner = o;
    cap_q.push_back(x);
  endtask

  // Watchdog: the whole run is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int c;
    logic [3:0] r;
    i_rst_n = 1'b0;
    i_req_valid = 4'b0000;
    i_req_data = 32'h0000_0000;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // All four valid from reset: round robin 0,1,2,3,0 every 6 cycles.
    c = cyc;
    i_req_data = 32'h1312_1110;
    i_req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      r = 4'b0001 << (k % 4);
      exp_grant(c + 1 + 6*k, r);
      exp_cap(c + 2 + 6*k, 8'h10 + 8'(k % 4), 2'(k % 4));
    end
    wait_cyc(c + 26);
    i_req_valid = 4'b0000;
    wait_cyc(c + 32);

    // Only requester 2, data 0x5A.
    c = cyc;
    i_req_data = 32'h005A_0000;
    i_req_valid = 4'b0100;
    exp_grant(c + 1, 4'b0100);
    exp_cap(c + 2, 8'h5A, 2'd2);
    wait_cyc(c + 2);
    i_req_valid = 4'b0000;
    wait_cyc(c + 8);

    // Requester 1 withdraws during GRANT; display untouched, pointer stays at 2.
    c = cyc;
    i_req_data = 32'h005A_4400;
    i_req_valid = 4'b0010;
    exp_grant(c + 1, 4'b0010);
    wait_cyc(c + 1);
    i_req_valid = 4'b0000;
    chk_data = 8'h5A;
    chk_owner = 2'd2;
    chk_en = 1'b1;
    wait_cyc(c + 6);
    i_req_data = 32'h0022_2100;
    i_req_valid = 4'b0110;
    exp_grant(c + 7, 4'b0010);
    exp_cap(c + 8, 8'h21, 2'd1);
    wait_cyc(c + 7);
    chk_en = 1'b0;
    wait_cyc(c + 8);
    i_req_valid = 4'b0000;
    wait_cyc(c + 14);

    // Requester 3 arrives mid-HOLD of owner 0; served right after the dwell.
    c = cyc;
    i_req_data = 32'h0000_0077;
    i_req_valid = 4'b0001;
    exp_grant(c + 1, 4'b0001);
    exp_cap(c + 2, 8'h77, 2'd0);
    wait_cyc(c + 2);
    i_req_valid = 4'b0000;
    wait_cyc(c + 3);
    i_req_data = 32'h3300_0077;
    i_req_valid = 4'b1000;
    exp_grant(c + 7, 4'b1000);
    exp_cap(c + 8, 8'h33, 2'd3);
    wait_cyc(c + 8);
    i_req_valid = 4'b0000;
    wait_cyc(c + 14);

    // Single request 0xC3 then 20 idle cycles: display holds, no grants.
    c = cyc;
    i_req_data = 32'h0000_C300;
    i_req_valid = 4'b0010;
    exp_grant(c + 1, 4'b0010);
    exp_cap(c + 2, 8'hC3, 2'd1);
    wait_cyc(c + 2);
    i_req_valid = 4'b0000;
    wait_cyc(c + 7);
    chk_data = 8'hC3;
    chk_owner = 2'd1;
    chk_en = 1'b1;
    wait_cyc(c + 27);
    chk_en = 1'b0;

    // Reset mid-HOLD, then first grant after release goes to index 0.
    c = cyc;
    i_req_data = 32'h1312_1110;
    i_req_valid = 4'b1111;
    exp_grant(c + 1, 4'b0100);
    exp_cap(c + 2, 8'h12, 2'd2);
    wait_cyc(c + 3);
    #2;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    c = cyc;
    exp_grant(c + 1, 4'b0001);
    exp_cap(c + 2, 8'h10, 2'd0);
    wait_cyc(c + 2);
    i_req_valid = 4'b0000;
    wait_cyc(c + 8);

    done = 1'b1;
    for (int k = 0; k < 5 && !mon_done; k++) @(negedge i_clk);
    #1;
    if (!mon_done) begin
      $display("FAIL monitor_finish: got not done expected done");
      $fatal(1, "monitor did not finish");
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
